// File: rtl/pon_on_delay_pkg.sv
// Shared types and constants for the power-on on-delay qualifier.
// The state encodings are fixed values so they stay stable when the design is viewed in a waveform.
package pon_on_delay_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ON   = 2'd2
    } pon_state_t;

    localparam logic [7:0] ABORT_MAX = 8'd255;

    // Saturating increment for the abort counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v == ABORT_MAX) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage : pon_on_delay_pkg

// File: rtl/pon_on_delay_sync.sv
// Multi-flop synchronizer that brings the asynchronous power-good request into the clk domain.
module pon_on_delay_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_r;

    // Shift chain; it clears asynchronously so a reset never leaves a stale request behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_r <= '0;
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
        end
    end

    assign q = chain_r[STAGES-1];

endmodule : pon_on_delay_sync

// File: rtl/pon_on_delay.sv
// Power-on qualifier: q asserts only after the synchronized request has stayed high for TD ticks,
// and drops on the first cycle that the synchronized request is seen low.
module pon_on_delay
    import pon_on_delay_pkg::*;
#(
    parameter int CLK_DIV     = 100,
    parameter int TD          = 3000,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d,
    output logic             q,
    output logic             busy,
    output logic [CNT_W-1:0] remain,
    output logic [7:0]       abort_cnt
);

    localparam int              PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] TD_C    = CNT_W'(TD);
    localparam logic [CNT_W-1:0] TD_LAST = CNT_W'(TD) - {{(CNT_W-1){1'b0}}, 1'b1};

    logic             d_s;
    logic             tick_s;

    pon_state_t       state_r;
    pon_state_t       state_next_s;
    logic [PW-1:0]    presc_r;
    logic [PW-1:0]    presc_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [7:0]       abort_r;
    logic [7:0]       abort_next_s;

    logic             q_next_s;
    logic             busy_next_s;
    logic [CNT_W-1:0] remain_next_s;
    logic             q_r;
    logic             busy_r;
    logic [CNT_W-1:0] remain_r;

    pon_on_delay_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d),
        .q     (d_s)
    );

    assign tick_s = (presc_r == PRE_LAST);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            presc_r <= '0;
            cnt_r   <= '0;
            abort_r <= 8'd0;
        end else begin
            state_r <= state_next_s;
            presc_r <= presc_next_s;
            cnt_r   <= cnt_next_s;
            abort_r <= abort_next_s;
        end
    end

    // Next-state logic; a low request in WAIT takes priority over a tick arriving in the same cycle.
    always_comb begin
        state_next_s = state_r;
        presc_next_s = presc_r;
        cnt_next_s   = cnt_r;
        abort_next_s = abort_r;
        case (state_r)
            ST_IDLE: begin
                presc_next_s = '0;
                cnt_next_s   = '0;
                if (d_s) begin
                    state_next_s = (TD == 0) ? ST_ON : ST_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!d_s) begin
                    state_next_s = ST_IDLE;
                    presc_next_s = '0;
                    cnt_next_s   = '0;
                    abort_next_s = sat_inc8(abort_r);
                end else if (tick_s) begin
                    presc_next_s = '0;
                    cnt_next_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == TD_LAST) begin
                        state_next_s = ST_ON;
                    end else begin
                        state_next_s = ST_WAIT;
                    end
                end else begin
                    presc_next_s = presc_r + {{(PW-1){1'b0}}, 1'b1};
                end
            end
            ST_ON: begin
                presc_next_s = '0;
                if (!d_s) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = '0;
                end else begin
                    state_next_s = ST_ON;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                presc_next_s = '0;
                cnt_next_s   = '0;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up with the state register.
    always_comb begin
        q_next_s      = 1'b0;
        busy_next_s   = 1'b0;
        remain_next_s = TD_C;
        case (state_next_s)
            ST_IDLE: begin
                remain_next_s = TD_C;
            end
            ST_WAIT: begin
                busy_next_s   = 1'b1;
                remain_next_s = TD_C - cnt_next_s;
            end
            ST_ON: begin
                q_next_s      = 1'b1;
                remain_next_s = '0;
            end
            default: begin
                remain_next_s = TD_C;
            end
        endcase
    end

    // Output registers; reset drops q asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r      <= 1'b0;
            busy_r   <= 1'b0;
            remain_r <= TD_C;
        end else begin
            q_r      <= q_next_s;
            busy_r   <= busy_next_s;
            remain_r <= remain_next_s;
        end
    end

    assign q         = q_r;
    assign busy      = busy_r;
    assign remain    = remain_r;
    assign abort_cnt = abort_r;

endmodule : pon_on_delay

// File: tb/tb_pon_on_delay.sv
// Directed bench for pon_on_delay: expectations are queued as stimulus is applied and checked after the DUT responds.
module tb_pon_on_delay;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        d;
    logic        d_z;
    logic        q, busy, q_z, busy_z;
    logic [15:0] remain, remain_z;
    logic [7:0]  abort_cnt, abort_z;

    int checks = 0;
    int passed = 0;

    typedef struct {
        string       tag;
        bit          sel;
        logic        q;
        logic        busy;
        logic [15:0] remain;
        logic [7:0]  abort;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pon_on_delay #(.CLK_DIV(4), .TD(5), .CNT_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .d(d),
        .q(q), .busy(busy), .remain(remain), .abort_cnt(abort_cnt)
    );

    pon_on_delay #(.CLK_DIV(4), .TD(0), .CNT_W(16), .SYNC_STAGES(2)) dut_z (
        .clk(clk), .rst_n(rst_n), .d(d_z),
        .q(q_z), .busy(busy_z), .remain(remain_z), .abort_cnt(abort_z)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input bit sel, input logic eq, input logic eb,
                        input logic [15:0] er, input logic [7:0] ea);
        exp_t e;
        e.tag = tag; e.sel = sel; e.q = eq; e.busy = eb; e.remain = er; e.abort = ea;
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            if (e.sel) begin
                cmp({e.tag, ".q"},      {15'd0, q_z},    {15'd0, e.q});
                cmp({e.tag, ".busy"},   {15'd0, busy_z}, {15'd0, e.busy});
                cmp({e.tag, ".remain"}, remain_z,        e.remain);
                cmp({e.tag, ".abort"},  {8'd0, abort_z}, {8'd0, e.abort});
            end else begin
                cmp({e.tag, ".q"},      {15'd0, q},         {15'd0, e.q});
                cmp({e.tag, ".busy"},   {15'd0, busy},      {15'd0, e.busy});
                cmp({e.tag, ".remain"}, remain,             e.remain);
                cmp({e.tag, ".abort"},  {8'd0, abort_cnt},  {8'd0, e.abort});
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        d     = 1'b0;
        d_z   = 1'b0;

        // 1: reset values, then release with d low
        push("reset", 1'b0, 1'b0, 1'b0, 16'd5, 8'd0);
        push("reset_z", 1'b1, 1'b0, 1'b0, 16'd0, 8'd0);
        step(2);
        check_pop();
        check_pop();
        rst_n = 1'b1;
        push("post_reset", 1'b0, 1'b0, 1'b0, 16'd5, 8'd0);
        step(3);
        check_pop();

        // 2: full qualification
        d = 1'b1;
        push("rise_e2", 1'b0, 1'b0, 1'b0, 16'd5, 8'd0);
        step(2);
        check_pop();
        push("rise_e3", 1'b0, 1'b0, 1'b1, 16'd5, 8'd0);
        step(1);
        check_pop();
        for (int k = 1; k <= 4; k++) begin
            push($sformatf("count_%0d", k), 1'b0, 1'b0, 1'b1, 16'(5 - k), 8'd0);
            step(4);
            check_pop();
        end
        push("qual_e22", 1'b0, 1'b0, 1'b1, 16'd1, 8'd0);
        step(3);
        check_pop();
        push("qual_e23", 1'b0, 1'b1, 1'b0, 16'd0, 8'd0);
        step(1);
        check_pop();

        // 4: release while on
        d = 1'b0;
        push("release_e2", 1'b0, 1'b1, 1'b0, 16'd0, 8'd0);
        step(2);
        check_pop();
        push("release_e3", 1'b0, 1'b0, 1'b0, 16'd5, 8'd0);
        step(1);
        check_pop();

        // 3: 10-cycle glitch, then a full hold
        d = 1'b1;
        push("glitch_mid", 1'b0, 1'b0, 1'b1, 16'd4, 8'd0);
        step(10);
        check_pop();
        d = 1'b0;
        push("glitch_abort", 1'b0, 1'b0, 1'b0, 16'd5, 8'd1);
        step(3);
        check_pop();
        d = 1'b1;
        push("requal_e22", 1'b0, 1'b0, 1'b1, 16'd1, 8'd1);
        step(22);
        check_pop();
        push("requal_e23", 1'b0, 1'b1, 1'b0, 16'd0, 8'd1);
        step(1);
        check_pop();
        d = 1'b0;
        push("requal_off", 1'b0, 1'b0, 1'b0, 16'd5, 8'd1);
        step(3);
        check_pop();

        // 5: abort counter saturation
        for (int i = 0; i < 260; i++) begin
            d = 1'b1;
            step(4);
            d = 1'b0;
            step(3);
            if (i == 252) begin
                push("sat_254", 1'b0, 1'b0, 1'b0, 16'd5, 8'd254);
                check_pop();
            end
        end
        push("sat_255", 1'b0, 1'b0, 1'b0, 16'd5, 8'd255);
        check_pop();

        // 6: reset in the middle of WAIT
        d = 1'b1;
        step(3);
        push("mid_wait", 1'b0, 1'b0, 1'b1, 16'd2, 8'd255);
        step(12);
        check_pop();
        rst_n = 1'b0;
        push("mid_reset", 1'b0, 1'b0, 1'b0, 16'd5, 8'd0);
        #1;
        check_pop();

        // 6: TD=0 instance, then reset while on
        d = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
        d_z = 1'b1;
        push("td0_e2", 1'b1, 1'b0, 1'b0, 16'd0, 8'd0);
        step(2);
        check_pop();
        push("td0_e3", 1'b1, 1'b1, 1'b0, 16'd0, 8'd0);
        step(1);
        check_pop();
        rst_n = 1'b0;
        push("td0_reset", 1'b1, 1'b0, 1'b0, 16'd0, 8'd0);
        #1;
        check_pop();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_pon_on_delay
